// File: rtl/bram_rv_initiator.sv
// Single-beat read/write initiator for the bram_rv valid/ready memory port, with a stall watchdog.
// Define BRAM_RV_INIT_WRITE_ACK_EN to return a response for every successful write.
module bram_rv_initiator #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,

    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic                    i_cmd_we,
    input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
    input  logic [DATA_WIDTH-1:0]   i_cmd_data,
    input  logic [DATA_WIDTH/8-1:0] i_cmd_be,

    output logic                    o_resp_valid,
    input  logic                    i_resp_ready,
    output logic [DATA_WIDTH-1:0]   o_resp_data,
    output logic                    o_resp_we,
    output logic                    o_resp_err,

    output logic [ADDR_WIDTH-1:0]   o_addr,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic [DATA_WIDTH/8-1:0] o_byte_write_enable,
    output logic                    o_wr_valid,
    input  logic                    i_wr_ready,
    output logic                    o_rd_ready,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic                    i_rd_valid
);

    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_RECOVER,
        ST_RESP
    } state_e;

    state_e                 state_q,     state_d;
    logic                   we_q,        we_d;
    logic [ADDR_WIDTH-1:0]  addr_q,      addr_d;
    logic [DATA_WIDTH-1:0]  data_q,      data_d;
    logic [BE_WIDTH-1:0]    be_q,        be_d;
    logic [CNT_WIDTH-1:0]   cnt_q,       cnt_d;
    logic [DATA_WIDTH-1:0]  resp_data_q, resp_data_d;
    logic                   resp_we_q,   resp_we_d;
    logic                   resp_err_q,  resp_err_d;

    logic timeout_hit;
    assign timeout_hit = (cnt_q == CNT_LAST);

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        data_d      = data_q;
        be_d        = be_q;
        cnt_d       = cnt_q;
        resp_data_d = resp_data_q;
        resp_we_d   = resp_we_q;
        resp_err_d  = resp_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    we_d    = i_cmd_we;
                    addr_d  = i_cmd_addr;
                    data_d  = i_cmd_data;
                    be_d    = i_cmd_be;
                    cnt_d   = '0;
                    state_d = i_cmd_we ? ST_WRITE : ST_READ;
                end
            end

            ST_WRITE: begin
                if (i_wr_ready) begin
`ifdef BRAM_RV_INIT_WRITE_ACK_EN
                    resp_data_d = '0;
                    resp_we_d   = 1'b1;
                    resp_err_d  = 1'b0;
                    state_d     = ST_RESP;
`else
                    state_d     = ST_RECOVER;
`endif
                end else if (timeout_hit) begin
                    resp_data_d = '0;
                    resp_we_d   = 1'b1;
                    resp_err_d  = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end

            // A handshake on the same edge as the timeout wins because it is tested first.
            ST_READ: begin
                if (i_rd_valid) begin
                    resp_data_d = i_data;
                    resp_we_d   = 1'b0;
                    resp_err_d  = 1'b0;
                    state_d     = ST_RESP;
                end else if (timeout_hit) begin
                    resp_data_d = '0;
                    resp_we_d   = 1'b0;
                    resp_err_d  = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end

            ST_RECOVER: state_d = ST_IDLE;

            ST_RESP: begin
                if (i_resp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!i_rst) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            be_q        <= '0;
            cnt_q       <= '0;
            resp_data_q <= '0;
            resp_we_q   <= 1'b0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            be_q        <= be_d;
            cnt_q       <= cnt_d;
            resp_data_q <= resp_data_d;
            resp_we_q   <= resp_we_d;
            resp_err_q  <= resp_err_d;
        end
    end

    // Outputs depend only on registers and the decoded state; ready is also held low during reset.
    assign o_cmd_ready         = (state_q == ST_IDLE) && i_rst;
    assign o_wr_valid          = (state_q == ST_WRITE);
    assign o_rd_ready          = (state_q == ST_READ);
    assign o_addr              = addr_q;
    assign o_data              = data_q;
    assign o_byte_write_enable = (state_q == ST_WRITE) ? be_q : '0;

    assign o_resp_valid = (state_q == ST_RESP);
    assign o_resp_data  = (state_q == ST_RESP) ? resp_data_q : '0;
    assign o_resp_we    = (state_q == ST_RESP) && resp_we_q;
    assign o_resp_err   = (state_q == ST_RESP) && resp_err_q;

endmodule

// File: tb/tb_bram_rv_initiator.sv
// Scoreboard bench for bram_rv_initiator against a behavioural bram_rv memory stub.
module tb_bram_rv_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [9:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic [3:0]  cmd_be;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_we;
    logic        resp_err;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_bwe;
    logic        wr_valid;
    logic        wr_ready;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        rd_valid;

    logic        rd_stall;
    logic        wr_stall;
    logic [31:0] mem [0:1023];
    int          cyc;

    typedef struct packed {
        logic [31:0] data;
        logic        we;
        logic        err;
    } resp_t;

    resp_t exp_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    always #5 clk = ~clk;

    bram_rv_initiator #(
        .ADDR_WIDTH    (10),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst_n),
        .i_cmd_valid        (cmd_valid),
        .o_cmd_ready        (cmd_ready),
        .i_cmd_we           (cmd_we),
        .i_cmd_addr         (cmd_addr),
        .i_cmd_data         (cmd_data),
        .i_cmd_be           (cmd_be),
        .o_resp_valid       (resp_valid),
        .i_resp_ready       (resp_ready),
        .o_resp_data        (resp_data),
        .o_resp_we          (resp_we),
        .o_resp_err         (resp_err),
        .o_addr             (mem_addr),
        .o_data             (mem_wdata),
        .o_byte_write_enable(mem_bwe),
        .o_wr_valid         (wr_valid),
        .i_wr_ready         (wr_ready),
        .o_rd_ready         (rd_ready),
        .i_data             (rd_data),
        .i_rd_valid         (rd_valid)
    );

    // Memory stub: writes land on the handshake edge, reads return one cycle after rd_ready rises.
    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] w;
        w = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) w[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return w;
    endfunction

    assign wr_ready = !wr_stall;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wr_valid && wr_ready) mem[mem_addr] <= merge(mem[mem_addr], mem_wdata, mem_bwe);
        rd_valid <= rd_ready && !rd_valid && !rd_stall;
        rd_data  <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per response handshake.
    always @(negedge clk) begin
        resp_t e;
        if (rst_n && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL resp_unexpected: got data 0x%08h we %0b err %0b, expected none",
                         resp_data, resp_we, resp_err);
            end else begin
                e = exp_q.pop_front();
                check("resp_data", resp_data, e.data);
                check("resp_we", {31'b0, resp_we}, {31'b0, e.we});
                check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
            end
        end
    end

    function automatic void expect_resp(input logic [31:0] d, input logic we, input logic err);
        resp_t e;
        e.data = d;
        e.we   = we;
        e.err  = err;
        exp_q.push_back(e);
    endfunction

    // Called and returns at posedge+#1; returns just after the accepting edge.
    task automatic send(input logic we, input logic [9:0] a, input logic [31:0] d,
                        input logic [3:0] be);
        int n = 0;
        while (!cmd_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check("cmd_ready_timeout", {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_be    = be;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
`ifdef BRAM_RV_INIT_WRITE_ACK_EN
        expect_resp(32'h0, 1'b1, 1'b0);
`endif
        send(1'b1, a, d, be);
    endtask

    task automatic read(input logic [9:0] a, input logic [31:0] exp_d);
        expect_resp(exp_d, 1'b0, 1'b0);
        send(1'b0, a, 32'h0, 4'h0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        int c0;
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_we     = 1'b0;
        cmd_addr   = '0;
        cmd_data   = '0;
        cmd_be     = '0;
        resp_ready = 1'b1;
        rd_stall   = 1'b0;
        wr_stall   = 1'b0;
        cyc        = 0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        check("rst_wr_valid", {31'b0, wr_valid}, 32'd0);
        check("rst_rd_ready", {31'b0, rd_ready}, 32'd0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_addr", {22'b0, mem_addr}, 32'd0);
        check("rst_bwe", {28'b0, mem_bwe}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("cmd_ready_after_rst", {31'b0, cmd_ready}, 32'd1);

        // Write one beat, then a timed read of the same address.
        send(1'b1, 10'd21, 32'hAA, 4'hF);
`ifdef BRAM_RV_INIT_WRITE_ACK_EN
        expect_resp(32'h0, 1'b1, 1'b0);
`endif
        check("wr_valid_e0", {31'b0, wr_valid}, 32'd1);
        check("wr_bwe_e0", {28'b0, mem_bwe}, 32'hF);
        @(posedge clk); #1;
        check("wr_valid_e1", {31'b0, wr_valid}, 32'd0);
        wait_drain();

        read(10'd21, 32'hAA);
        check("rd_ready_e0", {31'b0, rd_ready}, 32'd1);
        check("rd_bwe_e0", {28'b0, mem_bwe}, 32'h0);
        @(posedge clk); #1;
        check("resp_valid_e1", {31'b0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        check("resp_valid_e2", {31'b0, resp_valid}, 32'd1);
        wait_drain();

        // Ordered reads after three writes.
        write(10'd21, 32'hAA, 4'hF);
        write(10'd22, 32'hBB, 4'hF);
        write(10'd23, 32'hCC, 4'hF);
        read(10'd23, 32'hCC);
        read(10'd21, 32'hAA);
        read(10'd22, 32'hBB);
        wait_drain();

        // Partial byte-enable merge.
        write(10'd30, 32'h12345678, 4'hF);
        write(10'd30, 32'h2211FFEE, 4'b0011);
        read(10'd30, 32'h1234FFEE);
        wait_drain();

        // Back-to-back reads, one accept every four cycles.
        read(10'd21, 32'hAA);
        c0 = cyc;
        read(10'd23, 32'hCC);
        check("b2b_gap", cyc - c0, 4);
        wait_drain();

        // Response backpressure for five cycles.
        resp_ready = 1'b0;
        read(10'd22, 32'hBB);
        n = 0;
        while (!resp_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_resp_valid", {31'b0, resp_valid}, 32'd1);
            check("bp_resp_data", resp_data, 32'hBB);
            check("bp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_consumed", {31'b0, resp_valid}, 32'd0);
        wait_drain();

        // Read watchdog: rd_ready held for exactly 16 cycles, then an error response.
        rd_stall = 1'b1;
        expect_resp(32'h0, 1'b0, 1'b1);
        send(1'b0, 10'd21, 32'h0, 4'h0);
        n = 0;
        while (rd_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("rd_timeout_cycles", n, 16);
        wait_drain();
        rd_stall = 1'b0;

        // Write watchdog applies with or without write acks.
        wr_stall = 1'b1;
        expect_resp(32'h0, 1'b1, 1'b1);
        send(1'b1, 10'd40, 32'hDEADBEEF, 4'hF);
        wait_drain();
        wr_stall = 1'b0;

        // Reset in the middle of a read: no response, then a normal read.
        rd_stall = 1'b1;
        send(1'b0, 10'd21, 32'h0, 4'h0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_rd_ready", {31'b0, rd_ready}, 32'd0);
        check("midrst_wr_valid", {31'b0, wr_valid}, 32'd0);
        check("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("midrst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        rst_n    = 1'b1;
        rd_stall = 1'b0;
        #1;
        check("postrst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        read(10'd23, 32'hCC);
        wait_drain();
        repeat (5) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end

endmodule
